// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard transmitter: queues scan-code bytes and serialises them as
// 11-bit PS/2 frames toward the keyboard decoder, yielding to host inhibit.
//
// state   | meaning
// IDLE    | lines high, waiting for a queued byte and no inhibit
// TX_HIGH | ps2_clk high, frame bit[idx] presented on ps2_data
// TX_LOW  | ps2_clk low, decoder samples ps2_data
// GAP     | lines high, enforced idle time after a frame or an abort
module ps2_kbd_tx #(
  parameter int HALF       = 443,
  parameter int GAP        = 886,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] din,
  input  logic       wr,
  input  logic       inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TMAX  = (GAP > HALF) ? GAP : HALF;
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]       HALF_LD  = TW'(HALF - 1);
  localparam logic [TW-1:0]       GAP_LD   = TW'(GAP - 1);
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TX_HIGH = 2'd1,
    ST_TX_LOW  = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  state_t                state, state_nx;
  logic [TW-1:0]         timer, timer_nx;
  logic [3:0]            idx, idx_nx;
  logic                  pop;
  logic                  push;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   count;
  logic [7:0]            head;
  logic [10:0]           frame;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  // A write into a full FIFO is still taken when the head leaves the same cycle.
  assign push  = wr && (!full || pop);
  assign head  = mem[rptr];
  assign frame = {1'b1, ~^head, head, 1'b0};

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr && full && !pop;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      timer <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    idx_nx   = idx;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && !inhibit) begin
          state_nx = ST_TX_HIGH;
          idx_nx   = '0;
          timer_nx = HALF_LD;
        end
      end
      ST_TX_HIGH: begin
        if (inhibit) begin
          state_nx = ST_GAP;
          timer_nx = GAP_LD;
        end else if (timer == '0) begin
          state_nx = ST_TX_LOW;
          timer_nx = HALF_LD;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      ST_TX_LOW: begin
        if (inhibit) begin
          state_nx = ST_GAP;
          timer_nx = GAP_LD;
        end else if (timer == '0) begin
          if (idx == 4'd10) begin
            pop      = 1'b1;
            state_nx = ST_GAP;
            timer_nx = GAP_LD;
          end else begin
            state_nx = ST_TX_HIGH;
            idx_nx   = idx + 1'b1;
            timer_nx = HALF_LD;
          end
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      ST_GAP: begin
        // The idle period restarts for as long as the host keeps inhibiting.
        if (inhibit)            timer_nx = GAP_LD;
        else if (timer == '0)   state_nx = ST_IDLE;
        else                    timer_nx = timer - 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign ps2_clk  = (state != ST_TX_LOW);
  assign ps2_data = (state == ST_TX_HIGH || state == ST_TX_LOW) ? frame[idx] : 1'b1;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx with HALF=4, GAP=8: frame content, timing,
// FIFO full/overflow, inhibit abort and mid-frame reset.
module tb_ps2_kbd_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] din;
  logic       wr;
  logic       inhibit;
  logic       ps2_clk, ps2_data, full, empty, busy, overflow;

  int total = 0;
  int fails = 0;
  int cyc   = 0;
  int n_bits;

  bit bits[$];
  int starts[$];
  int ends[$];
  int falls[$];

  ps2_kbd_tx #(.HALF(4), .GAP(8), .DEPTH_LOG2(3)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .wr(wr), .inhibit(inhibit),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .full(full), .empty(empty),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cyc++;

  always @(negedge ps2_clk) begin
    bits.push_back(ps2_data);
    falls.push_back(cyc);
  end
  always @(posedge busy) starts.push_back(cyc);
  always @(negedge busy) ends.push_back(cyc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    bits.delete();
    starts.delete();
    ends.delete();
    falls.delete();
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy && empty) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_timeout", {31'd0, done}, 32'd1);
  endtask

  function automatic logic [10:0] get_frame(input int base);
    logic [10:0] f;
    for (int i = 0; i < 11; i++)
      f[i] = (base + i < bits.size()) ? bits[base + i] : 1'bx;
    return f;
  endfunction

  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  initial begin
    reset_n = 1'b0; wr = 1'b0; din = 8'h00; inhibit = 1'b0;
    #12;
    check("rst_ps2_clk",  {31'd0, ps2_clk},  32'd1);
    check("rst_ps2_data", {31'd0, ps2_data}, 32'd1);
    check("rst_full",     {31'd0, full},     32'd0);
    check("rst_empty",    {31'd0, empty},    32'd1);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();

    // Single frame 0x1C: latency, bit order, timing
    clear_logs();
    din = 8'h1C; wr = 1'b1;
    tick();
    wr = 1'b0;
    check("lat_n_data",  {31'd0, ps2_data}, 32'd1);
    check("lat_n_busy",  {31'd0, busy},     32'd0);
    check("lat_n_empty", {31'd0, empty},    32'd0);
    tick();
    check("lat_n1_data", {31'd0, ps2_data}, 32'd0);
    check("lat_n1_busy", {31'd0, busy},     32'd1);
    check("lat_n1_clk",  {31'd0, ps2_clk},  32'd1);
    wait_idle(300);
    check("f1c_nbits", bits.size(), 32'd11);
    check("f1c_frame", {21'd0, get_frame(0)}, 32'h438);
    check("f1c_empty", {31'd0, empty}, 32'd1);
    check("f1c_first_fall", falls.size() > 0 ? falls[0] - starts[0] : -1, 32'd4);
    check("f1c_bit_period", falls.size() > 1 ? falls[1] - falls[0] : -1, 32'd8);
    check("f1c_busy_len", ends.size() > 0 ? ends[0] - starts[0] : -1, 32'd96);

    // Back-to-back 0x00, 0xFF
    clear_logs();
    din = 8'h00; wr = 1'b1;
    tick();
    din = 8'hFF;
    tick();
    wr = 1'b0;
    wait_idle(400);
    check("b2b_nbits",  bits.size(), 32'd22);
    check("b2b_frame0", {21'd0, get_frame(0)},  32'h600);
    check("b2b_frame1", {21'd0, get_frame(11)}, 32'h7FE);
    check("b2b_spacing", starts.size() > 1 ? starts[1] - starts[0] : -1, 32'd97);

    // Fill under inhibit, overflow on the 9th write
    clear_logs();
    inhibit = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      din = 8'(8'h10 + i); wr = 1'b1;
      tick();
      if (i == 6) check("fill_full7", {31'd0, full}, 32'd0);
      if (i == 7) begin
        check("fill_full8", {31'd0, full}, 32'd1);
        check("fill_ovf8",  {31'd0, overflow}, 32'd0);
      end
      if (i == 8) check("fill_ovf9", {31'd0, overflow}, 32'd1);
    end
    wr = 1'b0;
    tick();
    check("fill_ovf_pulse", {31'd0, overflow}, 32'd0);
    check("fill_no_start",  {31'd0, busy},     32'd0);
    check("fill_still_full", {31'd0, full},    32'd1);
    inhibit = 1'b0;
    wait_idle(1200);
    check("fill_nbits", bits.size(), 32'd88);
    for (int i = 0; i < 8; i++)
      check($sformatf("fill_order%0d", i), {21'd0, get_frame(i * 11)},
            {21'd0, exp_frame(8'(8'h10 + i))});

    // Abort during data bit 3 of 0x5A, then retransmission
    clear_logs();
    din = 8'h5A; wr = 1'b1;
    tick();
    wr = 1'b0;
    for (int i = 0; i < 200 && bits.size() < 5; i++) tick();
    check("abort_reach_bit3", bits.size(), 32'd5);
    inhibit = 1'b1;
    tick();
    check("abort_clk_high",  {31'd0, ps2_clk},  32'd1);
    check("abort_data_high", {31'd0, ps2_data}, 32'd1);
    check("abort_busy",      {31'd0, busy},     32'd1);
    repeat (20) tick();
    check("abort_held_busy", {31'd0, busy}, 32'd1);
    check("abort_no_bits", bits.size(), 32'd5);
    inhibit = 1'b0;
    repeat (7) tick();
    check("abort_gap7_busy", {31'd0, busy}, 32'd1);
    tick();
    check("abort_gap8_idle", {31'd0, busy}, 32'd0);
    tick();
    check("abort_restart", {31'd0, busy}, 32'd1);
    wait_idle(300);
    check("abort_nbits", bits.size(), 32'd16);
    check("abort_partial", {27'd0, get_frame(0) & 11'h01F}, 32'h014);
    check("abort_resend", {21'd0, get_frame(5)}, 32'h6B4);

    // Reset mid-frame with 3 bytes queued
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      din = 8'(8'h31 + i); wr = 1'b1;
      tick();
    end
    wr = 1'b0;
    for (int i = 0; i < 50 && ps2_clk; i++) tick();
    check("rstmid_in_low", {31'd0, ps2_clk}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("rstmid_clk",   {31'd0, ps2_clk},  32'd1);
    check("rstmid_data",  {31'd0, ps2_data}, 32'd1);
    check("rstmid_empty", {31'd0, empty},    32'd1);
    check("rstmid_busy",  {31'd0, busy},     32'd0);
    n_bits = bits.size();
    tick();
    tick();
    reset_n = 1'b1;
    repeat (150) tick();
    check("rstmid_silent", bits.size(), n_bits);
    check("rstmid_busy_after", {31'd0, busy}, 32'd0);

    // Write on the pop cycle while full
    clear_logs();
    inhibit = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 8'(8'h20 + i); wr = 1'b1;
      tick();
    end
    wr = 1'b0;
    check("pop_full_before", {31'd0, full}, 32'd1);
    inhibit = 1'b0;
    repeat (88) tick();
    check("pop_full_prepop", {31'd0, full}, 32'd1);
    din = 8'hA5; wr = 1'b1;
    tick();
    wr = 1'b0;
    check("pop_full_kept",  {31'd0, full},     32'd1);
    check("pop_no_ovf",     {31'd0, overflow}, 32'd0);
    tick();
    check("pop_no_ovf_late", {31'd0, overflow}, 32'd0);
    wait_idle(1200);
    check("pop_nbits", bits.size(), 32'd99);
    check("pop_first", {21'd0, get_frame(0)},  {21'd0, exp_frame(8'h20)});
    check("pop_last",  {21'd0, get_frame(88)}, {21'd0, exp_frame(8'hA5)});

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
